seq_arith_unit: RTL and testbench

Parametrised, handshaked, multi-cycle arithmetic unit for the CPU datapath. It supports ADD, SUB, INC and DEC in one cycle. MUL (shift-add) and DIV (restoring) are iterative and take WORD_SIZE cycles, producing a double-width product or a quotient/remainder pair plus status flags. It sits between the decode/issue stage and writeback. Only one operation is in flight at a time, and it replaces the purely combinational arithmetic path.

---
 rtl/cpu_pkg.sv | 34 +++
 rtl/seq_arith_unit_if.sv | 31 +++
 rtl/seq_muldiv_core.sv | 80 ++++++++
 rtl/seq_arith_unit.sv | 157 +++++++++++++++
 tb/tb_seq_arith_unit.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU datapath types: opcodes, arithmetic-unit FSM states and status flags.
package cpu_pkg;

  localparam int WORD_SIZE_DEF = 19;

  typedef enum logic [4:0] {
    OP_ADD = 5'h00,
    OP_SUB = 5'h01,
    OP_MUL = 5'h02,
    OP_DIV = 5'h03,
    OP_INC = 5'h04,
    OP_DEC = 5'h05
  } arith_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } arith_state_e;

  typedef struct packed {
    logic carry;
    logic zero;
    logic ovf;
    logic dbz;
    logic illegal;
  } arith_flags_t;

  // MUL always iterates; DIV iterates only when the divisor is nonzero.
  function automatic logic is_iterative(logic [4:0] op, logic div_nz);
    return (op == OP_MUL) || ((op == OP_DIV) && div_nz);
  endfunction

endpackage

// File: rtl/seq_arith_unit_if.sv
// Request/response handshake bundle between issue, the arithmetic unit and writeback.
interface seq_arith_unit_if #(
  parameter int WORD_SIZE = cpu_pkg::WORD_SIZE_DEF
);
  logic                 in_valid;
  logic                 in_ready;
  logic [4:0]           opcode;
  logic [WORD_SIZE-1:0] operand_1;
  logic [WORD_SIZE-1:0] operand_2;
  logic                 out_valid;
  logic                 out_ready;
  logic [WORD_SIZE-1:0] result;
  logic [WORD_SIZE-1:0] result_hi;
  logic                 flag_carry;
  logic                 flag_zero;
  logic                 flag_ovf;
  logic                 flag_dbz;
  logic                 flag_illegal;

  modport master (
    output in_valid, opcode, operand_1, operand_2, out_ready,
    input  in_ready, out_valid, result, result_hi,
           flag_carry, flag_zero, flag_ovf, flag_dbz, flag_illegal
  );

  modport slave (
    input  in_valid, opcode, operand_1, operand_2, out_ready,
    output in_ready, out_valid, result, result_hi,
           flag_carry, flag_zero, flag_ovf, flag_dbz, flag_illegal
  );
endinterface

// File: rtl/seq_muldiv_core.sv
// Iterative datapath: shift-add multiply and restoring divide, one bit per cycle.
// hi_q is the accumulator (MUL) or remainder (DIV); lo_q is multiplier or quotient.
module seq_muldiv_core import cpu_pkg::*; #(
  parameter int WORD_SIZE = WORD_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic                 is_mul_i,
  input  logic [WORD_SIZE-1:0] opa_i,
  input  logic [WORD_SIZE-1:0] opb_i,
  output logic                 done_o,
  output logic [WORD_SIZE-1:0] hi_o,
  output logic [WORD_SIZE-1:0] lo_o
);
  localparam int W  = WORD_SIZE;
  localparam int CW = $clog2(W + 1);

  logic          busy_q, mul_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  hi_q, lo_q, opd_q;
  logic [W-1:0]  hi_d, lo_d;
  logic [W:0]    madd, shifted;
  logic [W-1:0]  diff;
  logic          fits;

  // One iteration step for whichever operation is running.
  always_comb begin
    madd    = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opd_q : '0)};
    shifted = {hi_q, lo_q[W-1]};
    fits    = (shifted >= {1'b0, opd_q});
    // When the trial subtract fits, the true difference is below the divisor,
    // so the truncated W-bit difference is exact.
    diff    = shifted[W-1:0] - opd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (mul_q) begin
      hi_d = madd[W:1];
      lo_d = {madd[0], lo_q[W-1:1]};
    end else if (fits) begin
      hi_d = diff;
      lo_d = {lo_q[W-2:0], 1'b1};
    end else begin
      hi_d = shifted[W-1:0];
      lo_d = {lo_q[W-2:0], 1'b0};
    end
  end

  // Load on start, then run exactly W iterations; busy drops the cycle after done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      mul_q  <= 1'b0;
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      opd_q  <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      mul_q  <= is_mul_i;
      cnt_q  <= CW'(W);
      hi_q   <= '0;
      lo_q   <= opa_i;
      opd_q  <= opb_i;
    end else if (busy_q) begin
      if (cnt_q == '0) begin
        busy_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - CW'(1);
        hi_q  <= hi_d;
        lo_q  <= lo_d;
      end
    end
  end

  assign done_o = busy_q && (cnt_q == '0);
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: rtl/seq_arith_unit.sv
// Handshaked arithmetic unit: single-cycle add/sub/inc/dec plus iterative mul/div.
// One operation in flight; results are registered and frozen until consumed.
module seq_arith_unit import cpu_pkg::*; #(
  parameter int WORD_SIZE = WORD_SIZE_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  seq_arith_unit_if.slave bus
);
  localparam int W = WORD_SIZE;

  arith_state_e state_q, state_d;
  logic [4:0]   op_q;
  logic [W-1:0] a_q, b_q, res_q, hi_q;
  arith_flags_t flags_q;
  logic         ovld_q;

  logic         accept, core_start, ld_simple, ld_core, retire;
  logic         core_done;
  logic [W-1:0] core_hi, core_lo;

  logic [W-1:0] b_eff, s_res, s_hi;
  logic [W:0]   add_w, sub_w;
  arith_flags_t s_flags, c_flags;

  seq_muldiv_core #(.WORD_SIZE(W)) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (core_start),
    .is_mul_i(bus.opcode == OP_MUL),
    .opa_i   (bus.operand_1),
    .opb_i   (bus.operand_2),
    .done_o  (core_done),
    .hi_o    (core_hi),
    .lo_o    (core_lo)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state and datapath strobes. Single-cycle ops compute in their first
  // DONE cycle from the latched operands, so the result lands one edge after accept.
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    core_start = 1'b0;
    ld_simple  = 1'b0;
    ld_core    = 1'b0;
    retire     = 1'b0;
    case (state_q)
      ST_IDLE: if (bus.in_valid) begin
        accept = 1'b1;
        if (is_iterative(bus.opcode, bus.operand_2 != '0)) begin
          core_start = 1'b1;
          state_d    = ST_CALC;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_CALC: if (core_done) begin
        ld_core = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (!ovld_q) begin
          ld_simple = 1'b1;
        end else if (bus.out_ready) begin
          retire  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Single-cycle results; only non-iterative ops (incl. divide-by-zero) reach this path.
  always_comb begin
    b_eff   = (op_q == OP_INC || op_q == OP_DEC) ? W'(1) : b_q;
    add_w   = {1'b0, a_q} + {1'b0, b_eff};
    sub_w   = {1'b0, a_q} - {1'b0, b_eff};
    s_res   = '0;
    s_hi    = '0;
    s_flags = '0;
    case (op_q)
      OP_ADD, OP_INC: begin
        s_res         = add_w[W-1:0];
        s_flags.carry = add_w[W];
        s_flags.ovf   = (a_q[W-1] == b_eff[W-1]) && (add_w[W-1] != a_q[W-1]);
      end
      OP_SUB, OP_DEC: begin
        s_res         = sub_w[W-1:0];
        s_flags.carry = sub_w[W];
        s_flags.ovf   = (a_q[W-1] != b_eff[W-1]) && (sub_w[W-1] != a_q[W-1]);
      end
      OP_DIV: begin
        s_res       = '1;
        s_hi        = a_q;
        s_flags.dbz = 1'b1;
      end
      default: s_flags.illegal = 1'b1;
    endcase
    s_flags.zero = (s_res == '0);
  end

  // Flags for a finished MUL/DIV.
  always_comb begin
    c_flags      = '0;
    c_flags.zero = (core_lo == '0);
    c_flags.ovf  = (op_q == OP_MUL) && (core_hi != '0);
  end

  // Operand latch and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      hi_q    <= '0;
      flags_q <= '0;
      ovld_q  <= 1'b0;
    end else begin
      if (accept) begin
        op_q <= bus.opcode;
        a_q  <= bus.operand_1;
        b_q  <= bus.operand_2;
      end
      if (ld_simple) begin
        res_q   <= s_res;
        hi_q    <= s_hi;
        flags_q <= s_flags;
        ovld_q  <= 1'b1;
      end else if (ld_core) begin
        res_q   <= core_lo;
        hi_q    <= core_hi;
        flags_q <= c_flags;
        ovld_q  <= 1'b1;
      end else if (retire) begin
        ovld_q  <= 1'b0;
      end
    end
  end

  assign bus.in_ready     = (state_q == ST_IDLE);
  assign bus.out_valid    = ovld_q;
  assign bus.result       = res_q;
  assign bus.result_hi    = hi_q;
  assign bus.flag_carry   = flags_q.carry;
  assign bus.flag_zero    = flags_q.zero;
  assign bus.flag_ovf     = flags_q.ovf;
  assign bus.flag_dbz     = flags_q.dbz;
  assign bus.flag_illegal = flags_q.illegal;

endmodule

// File: tb/tb_seq_arith_unit.sv
// Directed bench for seq_arith_unit at WORD_SIZE=19.
// Flag vectors are ordered {carry, zero, ovf, dbz, illegal}.
module tb_seq_arith_unit;
  import cpu_pkg::*;

  localparam int W = 19;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  seq_arith_unit_if #(.WORD_SIZE(W)) bus();

  seq_arith_unit #(.WORD_SIZE(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] flags();
    return {bus.flag_carry, bus.flag_zero, bus.flag_ovf, bus.flag_dbz, bus.flag_illegal};
  endfunction

  // Present a request at a negedge; it is accepted on the following posedge.
  // Inputs are scrambled right after so late changes would be visible.
  task automatic issue(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.opcode = op; bus.operand_1 = a; bus.operand_2 = b; bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0; bus.opcode = 5'h1F; bus.operand_1 = ~a; bus.operand_2 = ~b;
  endtask

  // Edges after acceptance until out_valid; -1 if it never comes.
  task automatic wait_out(output int lat);
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic retire();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
    checks++; if ({bus.result, bus.result_hi, flags()} !== '0) begin errors++; $display("FAIL reset_outputs got %h/%h/%b exp 0", bus.result, bus.result_hi, flags()); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_add();
    int lat;
    issue(OP_ADD, 19'h7FFFF, 19'h00001);
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL add_busy in_ready got %b exp 0", bus.in_ready); end
    wait_out(lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL add_wrap latency got %0d exp 1", lat); end
    checks++; if (bus.result !== 19'h0) begin errors++; $display("FAIL add_wrap result got %h exp 0", bus.result); end
    checks++; if (flags() !== 5'b11000) begin errors++; $display("FAIL add_wrap flags got %b exp 11000", flags()); end
    retire();
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL add_retire rdy/vld got %b%b exp 10", bus.in_ready, bus.out_valid); end
    issue(OP_ADD, 19'h3FFFF, 19'h00001);
    wait_out(lat);
    checks++; if (bus.result !== 19'h40000) begin errors++; $display("FAIL add_ovf result got %h exp 40000", bus.result); end
    checks++; if (flags() !== 5'b00100) begin errors++; $display("FAIL add_ovf flags got %b exp 00100", flags()); end
    retire();
  endtask

  task automatic test_mul();
    int lat;
    issue(OP_MUL, 19'd1000, 19'd600);
    wait_out(lat);
    checks++; if (lat !== 20) begin errors++; $display("FAIL mul latency got %0d exp 20", lat); end
    checks++; if (bus.result !== 19'h127C0) begin errors++; $display("FAIL mul result got %h exp 127c0", bus.result); end
    checks++; if (bus.result_hi !== 19'h00001) begin errors++; $display("FAIL mul result_hi got %h exp 00001", bus.result_hi); end
    checks++; if (flags() !== 5'b00100) begin errors++; $display("FAIL mul flags got %b exp 00100", flags()); end
    retire();
  endtask

  task automatic test_div();
    int lat;
    issue(OP_DIV, 19'd1000, 19'd7);
    wait_out(lat);
    checks++; if (lat !== 20) begin errors++; $display("FAIL div latency got %0d exp 20", lat); end
    checks++; if ({bus.result, bus.result_hi} !== {19'd142, 19'd6}) begin errors++; $display("FAIL div q/r got %0d/%0d exp 142/6", bus.result, bus.result_hi); end
    checks++; if (flags() !== 5'b00000) begin errors++; $display("FAIL div flags got %b exp 00000", flags()); end
    retire();
    issue(OP_DIV, 19'd1234, 19'd0);
    wait_out(lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL dbz latency got %0d exp 1", lat); end
    checks++; if ({bus.result, bus.result_hi} !== {19'h7FFFF, 19'h004D2}) begin errors++; $display("FAIL dbz q/r got %h/%h exp 7ffff/004d2", bus.result, bus.result_hi); end
    checks++; if (flags() !== 5'b00010) begin errors++; $display("FAIL dbz flags got %b exp 00010", flags()); end
    retire();
    issue(OP_DIV, 19'd5, 19'd9);
    wait_out(lat);
    checks++; if ({bus.result, bus.result_hi} !== {19'd0, 19'd5}) begin errors++; $display("FAIL div_small q/r got %0d/%0d exp 0/5", bus.result, bus.result_hi); end
    checks++; if (flags() !== 5'b01000) begin errors++; $display("FAIL div_small flags got %b exp 01000", flags()); end
    retire();
    issue(OP_DIV, 19'h7FFFF, 19'd1);
    wait_out(lat);
    checks++; if ({bus.result, bus.result_hi} !== {19'h7FFFF, 19'd0}) begin errors++; $display("FAIL div_max q/r got %h/%h exp 7ffff/0", bus.result, bus.result_hi); end
    retire();
  endtask

  task automatic test_sub_dec_illegal();
    int lat;
    issue(OP_SUB, 19'd5, 19'd9);
    wait_out(lat);
    checks++; if (bus.result !== 19'h7FFFC) begin errors++; $display("FAIL sub result got %h exp 7fffc", bus.result); end
    checks++; if (flags() !== 5'b10000) begin errors++; $display("FAIL sub flags got %b exp 10000", flags()); end
    retire();
    issue(OP_DEC, 19'd0, 19'd123);
    wait_out(lat);
    checks++; if (bus.result !== 19'h7FFFF) begin errors++; $display("FAIL dec result got %h exp 7ffff", bus.result); end
    checks++; if (flags() !== 5'b10000) begin errors++; $display("FAIL dec flags got %b exp 10000", flags()); end
    retire();
    issue(OP_INC, 19'h7FFFF, 19'd55);
    wait_out(lat);
    checks++; if ({bus.result, flags()} !== {19'h0, 5'b11000}) begin errors++; $display("FAIL inc res/flags got %h/%b exp 0/11000", bus.result, flags()); end
    retire();
    issue(5'h1F, 19'd77, 19'd88);
    wait_out(lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL illegal latency got %0d exp 1", lat); end
    checks++; if ({bus.result, bus.result_hi} !== '0) begin errors++; $display("FAIL illegal res got %h/%h exp 0/0", bus.result, bus.result_hi); end
    checks++; if (flags() !== 5'b01001) begin errors++; $display("FAIL illegal flags got %b exp 01001", flags()); end
    retire();
  endtask

  task automatic test_backpressure();
    int lat;
    issue(OP_MUL, 19'h7FFFF, 19'h7FFFF);
    wait_out(lat);
    checks++; if (lat !== 20) begin errors++; $display("FAIL bp_mul latency got %0d exp 20", lat); end
    checks++; if ({bus.result, bus.result_hi, flags()} !== {19'h00001, 19'h7FFFE, 5'b00100}) begin errors++; $display("FAIL bp_mul got %h/%h/%b exp 00001/7fffe/00100", bus.result, bus.result_hi, flags()); end
    @(negedge clk);
    bus.opcode = OP_ADD; bus.operand_1 = 19'd1; bus.operand_2 = 19'd1; bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({bus.out_valid, bus.in_ready, bus.result, bus.result_hi, flags()} !== {2'b10, 19'h00001, 19'h7FFFE, 5'b00100}) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got vld%b rdy%b %h/%h/%b", i, bus.out_valid, bus.in_ready, bus.result, bus.result_hi, flags());
      end
    end
    bus.in_valid = 1'b0;
    retire();
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_release rdy/vld got %b%b exp 10", bus.in_ready, bus.out_valid); end
    @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ignored vld/rdy got %b%b exp 01", bus.out_valid, bus.in_ready); end
  endtask

  task automatic test_reset_mid();
    int lat;
    bit seen;
    issue(OP_MUL, 19'd3, 19'd4);
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid rdy/vld got %b%b exp 10", bus.in_ready, bus.out_valid); end
    checks++; if ({bus.result, bus.result_hi, flags()} !== '0) begin errors++; $display("FAIL rst_mid outputs got %h/%h/%b exp 0", bus.result, bus.result_hi, flags()); end
    @(negedge clk) rst_n = 1'b1;
    seen = 1'b0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_mid stale result got out_valid=1 exp 0"); end
    issue(OP_ADD, 19'd2, 19'd2);
    wait_out(lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL post_rst latency got %0d exp 1", lat); end
    checks++; if ({bus.result, bus.result_hi, flags()} !== {19'd4, 19'd0, 5'b00000}) begin errors++; $display("FAIL post_rst got %h/%h/%b exp 4/0/00000", bus.result, bus.result_hi, flags()); end
    retire();
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.opcode = '0; bus.operand_1 = '0; bus.operand_2 = '0;
    test_reset();
    test_add();
    test_mul();
    test_div();
    test_sub_dec_illegal();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
